mux_reg_pipe: RTL

//  Parametrised successor to the single-bit dff / 2:1 mux primitive pair.
//  - Selects one of CHANNELS data words with a registered mux.
//  - Carries the word through a DEPTH-stage valid/ready register pipeline.
//  - Reports pipeline occupancy and a sticky bad-select error.
//  - Sits between multi-source producers and a single back-pressuring consumer.

---
 rtl/mux_pipe_pkg.sv | 22 ++
 rtl/pipe_stage.sv | 49 ++++
 rtl/mux_reg_pipe.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mux_pipe_pkg.sv
// Shared definitions for the mux_reg_pipe block.
//   clog2_min1(n) : bit width needed to hold 0..n-1, never less than 1
//   DEF_*         : default WIDTH / CHANNELS / DEPTH for the top level
package mux_pipe_pkg;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_CHANNELS = 2;
    localparam int DEF_DEPTH    = 2;

    // Loop form (rather than $clog2) keeps a 1-bit minimum for n <= 2.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One valid/ready register slice.
//   clk, rst      : rising-edge clock, synchronous active-high reset
//   in_v/in_r/in_d    : upstream handshake and payload
//   out_v/out_r/out_d : downstream handshake and payload
// The slice accepts whenever it is empty or its own word is leaving, so
// in_r depends only on the local valid flop and out_r (never on in_v).
module pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_v,
    output logic         in_r,
    input  logic [W-1:0] in_d,
    output logic         out_v,
    input  logic         out_r,
    output logic [W-1:0] out_d
);

    logic         v_q, v_d;
    logic [W-1:0] d_q, d_d;

    always_comb begin
        in_r = !v_q || out_r;
        v_d  = v_q;
        d_d  = d_q;
        if (in_r) begin
            v_d = in_v;
            // Payload only moves on an actual accept, so idle data stays quiet.
            if (in_v) begin
                d_d = in_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= 1'b0;
            d_q <= '0;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    assign out_v = v_q;
    assign out_d = d_q;

endmodule

// File: rtl/mux_reg_pipe.sv
// Registered channel mux feeding a DEPTH-stage valid/ready pipeline.
//   clk, rst    : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready : producer handshake
//   in_data     : CHANNELS packed words, channel k at [k*WIDTH +: WIDTH]
//   in_sel      : channel select, travels with the word as out_sel
//   out_valid/out_ready : consumer handshake
//   out_data    : selected word (0 when the select was out of range)
//   out_sel     : raw select value captured with the word
//   occupancy   : registered count of valid stages, 0..DEPTH
//   sel_err     : sticky flag, an accepted select was >= CHANNELS
module mux_reg_pipe
    import mux_pipe_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int SELW     = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [CHANNELS*WIDTH-1:0]         in_data,
    input  logic [SELW-1:0]                   in_sel,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [WIDTH-1:0]                  out_data,
    output logic [SELW-1:0]                   out_sel,
    output logic [clog2_min1(DEPTH+1)-1:0]    occupancy,
    output logic                              sel_err
);

    localparam int SW   = WIDTH + SELW;
    localparam int OCCW = clog2_min1(DEPTH + 1);

    logic [WIDTH-1:0] mux_data;
    logic             bad_sel;
    logic [SW-1:0]    head_d;
    logic             ready_0;
    logic             tail_v;
    logic [SW-1:0]    tail_d;
    logic             push, pop;

    logic [OCCW-1:0]  occ_q, occ_d;
    logic             sel_err_q, sel_err_d;

    // Loop compare instead of an indexed part-select so an out-of-range
    // select yields 0 rather than reading past the end of in_data.
    always_comb begin
        mux_data = '0;
        bad_sel  = int'(in_sel) >= CHANNELS;
        for (int k = 0; k < CHANNELS; k++) begin
            if (int'(in_sel) == k) begin
                mux_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign head_d = {in_sel, mux_data};

    // Each generate block owns its own handshake nets; the ready chain runs
    // backwards through the blocks without forming a self-dependent vector.
    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic          in_v, in_r, out_v, out_r;
        logic [SW-1:0] in_d, out_d;

        if (g == 0) begin : g_head
            assign in_v = in_valid;
            assign in_d = head_d;
        end else begin : g_link
            assign in_v = g_stage[g-1].out_v;
            assign in_d = g_stage[g-1].out_d;
        end

        if (g == DEPTH - 1) begin : g_tail
            assign out_r = out_ready;
        end else begin : g_back
            assign out_r = g_stage[g+1].in_r;
        end

        pipe_stage #(.W(SW)) u_stage (
            .clk   (clk),
            .rst   (rst),
            .in_v  (in_v),
            .in_r  (in_r),
            .in_d  (in_d),
            .out_v (out_v),
            .out_r (out_r),
            .out_d (out_d)
        );
    end

    assign ready_0 = g_stage[0].in_r;
    assign tail_v  = g_stage[DEPTH-1].out_v;
    assign tail_d  = g_stage[DEPTH-1].out_d;

    // Both handshakes are held low while rst is high so nothing is seen to
    // transfer on the cycle that discards the pipeline.
    assign in_ready  = ready_0 && !rst;
    assign out_valid = tail_v && !rst;
    assign out_data  = tail_d[WIDTH-1:0];
    assign out_sel   = tail_d[SW-1:WIDTH];

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        occ_d     = occ_q;
        sel_err_d = sel_err_q || (push && bad_sel);
        if (push && !pop) begin
            occ_d = occ_q + OCCW'(1);
        end else if (pop && !push) begin
            occ_d = occ_q - OCCW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q     <= '0;
            sel_err_q <= 1'b0;
        end else begin
            occ_q     <= occ_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign occupancy = occ_q;
    assign sel_err   = sel_err_q;

endmodule
